// File: rtl/alarm_clock_multi_if.sv
// alarm_clock_multi_if: control inputs and time/alarm/ring outputs of the multi-alarm clock.
interface alarm_clock_multi_if #(
    parameter int NUM_ALARMS = 4,
    parameter int AW = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
);
    logic [1:0] mode;
    logic [AW-1:0] alarm_sel;
    logic btn_hr;
    logic btn_min;
    logic [NUM_ALARMS-1:0] alarm_en;
    logic snooze;
    logic stop;
    logic [4:0] hrs;
    logic [5:0] mins;
    logic [5:0] secs;
    logic [4:0] alarm_hrs;
    logic [5:0] alarm_mins;
    logic ringing;
    logic [AW-1:0] ring_id;
    logic sec_pulse;
    modport master (
        output mode, alarm_sel, btn_hr, btn_min, alarm_en, snooze, stop,
        input hrs, mins, secs, alarm_hrs, alarm_mins, ringing, ring_id, sec_pulse
    );
    modport slave (
        input mode, alarm_sel, btn_hr, btn_min, alarm_en, snooze, stop,
        output hrs, mins, secs, alarm_hrs, alarm_mins, ringing, ring_id, sec_pulse
    );
endinterface

// File: rtl/alarm_clock_multi.sv
// alarm_clock_multi: 24h clock with N alarms, hold-to-repeat setting and ring/snooze/timeout FSM.
module alarm_clock_multi #(
    parameter int CLK_HZ = 125000000,
    parameter int REPEAT_DIV = 62500000,
    parameter int NUM_ALARMS = 4,
    parameter int SNOOZE_MINS = 5,
    parameter int RING_MINS = 10
) (
    input logic clk,
    input logic reset,
    alarm_clock_multi_if.slave bus
);
    localparam int AW = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1;
    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int RW = (REPEAT_DIV > 1) ? $clog2(REPEAT_DIV) : 1;
    localparam int RING_T = RING_MINS * 60;
    localparam int SNZ_T = SNOOZE_MINS * 60;
    localparam int TW = $clog2(RING_T);
    localparam int SW = $clog2(SNZ_T + 1);
    typedef enum logic [1:0] {IDLE, RING, SNOOZE} state_t;
    state_t st;
    logic [PW-1:0] pre;
    logic [RW-1:0] rpt, rpt_cur;
    logic [TW-1:0] rtmr;
    logic [SW-1:0] scnt;
    logic [4:0] ah [NUM_ALARMS];
    logic [5:0] am [NUM_ALARMS];
    logic hr_q, stop_q, snz_q;
    logic run, set_t, set_a, tick, held, hr_rise, inc, inc_hr, inc_min, stop_e, snz_e, abort, hit;
    logic [AW-1:0] hit_id;
    always_comb begin
        run = bus.mode[1] == bus.mode[0];
        set_t = bus.mode == 2'b01;
        set_a = bus.mode == 2'b10;
        tick = run && pre == PW'(CLK_HZ - 1);
        held = !run && (bus.btn_hr || bus.btn_min);
        hr_rise = bus.btn_hr && !hr_q;
        // A fresh hr press restarts the repeat phase even if btn_min was already held
        rpt_cur = hr_rise ? '0 : rpt;
        inc = held && rpt_cur == '0;
        inc_hr = inc && bus.btn_hr;
        inc_min = inc && !bus.btn_hr;
        stop_e = bus.stop && !stop_q;
        snz_e = bus.snooze && !snz_q;
        abort = !run || !bus.alarm_en[bus.ring_id];
        hit = 1'b0;
        hit_id = '0;
        for (int i = NUM_ALARMS - 1; i >= 0; i--)
            if (bus.alarm_en[i] && ah[i] == bus.hrs && am[i] == bus.mins) begin
                hit = 1'b1;
                hit_id = AW'(i);
            end
        // Only a tick that just landed on hh:mm:00 counts; resets and edits never pulse sec_pulse
        hit = hit && run && bus.sec_pulse && bus.secs == '0;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre <= '0;
            rpt <= '0;
            hr_q <= 1'b0;
            stop_q <= 1'b0;
            snz_q <= 1'b0;
            bus.hrs <= '0;
            bus.mins <= '0;
            bus.secs <= '0;
            bus.sec_pulse <= 1'b0;
            bus.alarm_hrs <= '0;
            bus.alarm_mins <= '0;
            for (int i = 0; i < NUM_ALARMS; i++) begin
                ah[i] <= '0;
                am[i] <= '0;
            end
        end else begin
            pre <= (set_t || pre == PW'(CLK_HZ - 1)) ? '0 : pre + 1'b1;
            rpt <= !held ? '0 : (rpt_cur == RW'(REPEAT_DIV - 1)) ? '0 : rpt_cur + 1'b1;
            hr_q <= bus.btn_hr;
            stop_q <= bus.stop;
            snz_q <= bus.snooze;
            bus.sec_pulse <= tick;
            if (set_t) begin
                bus.secs <= '0;
                if (inc_hr) bus.hrs <= (bus.hrs == 5'd23) ? '0 : bus.hrs + 5'd1;
                if (inc_min) bus.mins <= (bus.mins == 6'd59) ? '0 : bus.mins + 6'd1;
            end else if (tick) begin
                bus.secs <= (bus.secs == 6'd59) ? '0 : bus.secs + 6'd1;
                if (bus.secs == 6'd59) begin
                    bus.mins <= (bus.mins == 6'd59) ? '0 : bus.mins + 6'd1;
                    if (bus.mins == 6'd59) bus.hrs <= (bus.hrs == 5'd23) ? '0 : bus.hrs + 5'd1;
                end
            end
            for (int i = 0; i < NUM_ALARMS; i++)
                if (set_a && bus.alarm_sel == AW'(i)) begin
                    if (inc_hr) ah[i] <= (ah[i] == 5'd23) ? '0 : ah[i] + 5'd1;
                    if (inc_min) am[i] <= (am[i] == 6'd59) ? '0 : am[i] + 6'd1;
                end
            bus.alarm_hrs <= (int'(bus.alarm_sel) < NUM_ALARMS) ? ah[bus.alarm_sel] : '0;
            bus.alarm_mins <= (int'(bus.alarm_sel) < NUM_ALARMS) ? am[bus.alarm_sel] : '0;
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st <= IDLE;
            bus.ringing <= 1'b0;
            bus.ring_id <= '0;
            rtmr <= '0;
            scnt <= '0;
        end else begin
            case (st)
                IDLE: if (hit) begin
                    st <= RING;
                    bus.ringing <= 1'b1;
                    bus.ring_id <= hit_id;
                    rtmr <= '0;
                end
                RING: if (abort || stop_e || (tick && rtmr == TW'(RING_T - 1))) begin
                    st <= IDLE;
                    bus.ringing <= 1'b0;
                end else if (snz_e) begin
                    st <= SNOOZE;
                    bus.ringing <= 1'b0;
                    scnt <= SW'(SNZ_T);
                end else if (tick) rtmr <= rtmr + 1'b1;
                SNOOZE: if (abort || stop_e) st <= IDLE;
                else if (hit || scnt == '0) begin
                    st <= RING;
                    bus.ringing <= 1'b1;
                    rtmr <= '0;
                    if (hit) bus.ring_id <= hit_id;
                end else if (tick) scnt <= scnt - 1'b1;
                default: begin
                    st <= IDLE;
                    bus.ringing <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alarm_clock_multi.sv
// tb_alarm_clock_multi: directed checks of setting, rollover, alarm priority, snooze, timeout, abort and async reset.
module tb_alarm_clock_multi;
    logic clk = 1'b0;
    logic reset;
    int checks = 0;
    int failures = 0;
    int n, gap_bad, last, cyc_n;
    alarm_clock_multi_if #(.NUM_ALARMS(4)) bus ();
    alarm_clock_multi #(
        .CLK_HZ(10), .REPEAT_DIV(4), .NUM_ALARMS(4), .SNOOZE_MINS(1), .RING_MINS(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask
    task automatic cyc(input int k);
        repeat (k) @(negedge clk);
    endtask
    task automatic hold(input logic h, input logic m, input int k);
        bus.btn_hr = h;
        bus.btn_min = m;
        cyc(k);
        bus.btn_hr = 1'b0;
        bus.btn_min = 1'b0;
        cyc(1);
    endtask
    task automatic pulse(input logic st, input logic sn);
        bus.stop = st;
        bus.snooze = sn;
        cyc(1);
        bus.stop = 1'b0;
        bus.snooze = 1'b0;
    endtask
    task automatic set_alarm(input int sel, input int k);
        bus.mode = 2'b10;
        bus.alarm_sel = 2'(sel);
        cyc(1);
        hold(1'b0, 1'b1, k);
    endtask
    task automatic wait_ring(input string tag, input int lim);
        for (int i = 0; i < lim && !bus.ringing; i++) cyc(1);
        check(tag, int'(bus.ringing), 1);
    endtask
    task automatic count_ticks(input logic lvl, input int lim, output int cnt);
        cnt = 0;
        for (int i = 0; i < lim; i++) begin
            cyc(1);
            if (bus.sec_pulse) cnt++;
            if (bus.ringing == lvl) break;
        end
    endtask
    initial begin
        reset = 1'b1;
        bus.mode = 2'b00;
        bus.alarm_sel = '0;
        bus.btn_hr = 1'b0;
        bus.btn_min = 1'b0;
        bus.alarm_en = 4'b1111;
        bus.snooze = 1'b0;
        bus.stop = 1'b0;
        cyc(2);
        reset = 1'b0;
        check("rst_hrs", int'(bus.hrs), 0);
        check("rst_mins", int'(bus.mins), 0);
        check("rst_secs", int'(bus.secs), 0);
        check("rst_ringing", int'(bus.ringing), 0);
        check("rst_ring_id", int'(bus.ring_id), 0);
        check("rst_sec_pulse", int'(bus.sec_pulse), 0);
        check("rst_alarm_mins", int'(bus.alarm_mins), 0);
        cyc(30);
        check("no_ring_after_rst", int'(bus.ringing), 0);
        // setting with hold-to-repeat
        bus.mode = 2'b01;
        hold(1'b0, 1'b1, 225);
        check("set_min_57", int'(bus.mins), 57);
        check("set_secs_held", int'(bus.secs), 0);
        hold(1'b0, 1'b1, 13);
        check("repeat_mins", int'(bus.mins), 1);
        check("repeat_hrs", int'(bus.hrs), 0);
        hold(1'b1, 1'b1, 5);
        check("prio_hrs", int'(bus.hrs), 2);
        check("prio_mins", int'(bus.mins), 1);
        hold(1'b1, 1'b0, 81);
        hold(1'b0, 1'b1, 229);
        check("set_hrs_23", int'(bus.hrs), 23);
        check("set_mins_59", int'(bus.mins), 59);
        // rollover 23:59:00 -> 00:00:00
        bus.alarm_en = 4'b0000;
        bus.mode = 2'b00;
        n = 0;
        gap_bad = 0;
        last = 0;
        cyc_n = 0;
        for (int i = 0; i < 1000 && n < 60; i++) begin
            cyc(1);
            cyc_n++;
            if (bus.sec_pulse) begin
                if (n > 0 && cyc_n - last != 10) gap_bad++;
                last = cyc_n;
                n++;
            end
        end
        check("roll_pulses", n, 60);
        check("roll_gaps", gap_bad, 0);
        check("roll_hrs", int'(bus.hrs), 0);
        check("roll_mins", int'(bus.mins), 0);
        check("roll_secs", int'(bus.secs), 0);
        // two alarms at 00:01, lowest enabled index wins
        set_alarm(1, 1);
        set_alarm(2, 1);
        check("alm2_mins", int'(bus.alarm_mins), 1);
        bus.alarm_sel = 2'd0;
        cyc(2);
        check("alm0_mins", int'(bus.alarm_mins), 0);
        bus.alarm_en = 4'b0110;
        bus.mode = 2'b00;
        wait_ring("ring_a1", 800);
        check("ring_a1_id", int'(bus.ring_id), 1);
        check("ring_a1_mins", int'(bus.mins), 1);
        check("ring_a1_secs", int'(bus.secs), 0);
        pulse(1'b1, 1'b0);
        check("stop_a1", int'(bus.ringing), 0);
        set_alarm(1, 1);
        set_alarm(2, 1);
        bus.alarm_en = 4'b0100;
        bus.mode = 2'b00;
        wait_ring("ring_a2", 800);
        check("ring_a2_id", int'(bus.ring_id), 2);
        check("ring_a2_mins", int'(bus.mins), 2);
        // snooze for 60 ticks then ring again
        for (int i = 0; i < 20 && !bus.sec_pulse; i++) cyc(1);
        pulse(1'b0, 1'b1);
        check("snooze_quiet", int'(bus.ringing), 0);
        count_ticks(1'b1, 800, n);
        check("snooze_ticks", n, 60);
        check("snooze_rering", int'(bus.ringing), 1);
        check("snooze_id", int'(bus.ring_id), 2);
        pulse(1'b1, 1'b0);
        check("stop_after_snz", int'(bus.ringing), 0);
        // stop and snooze together go idle
        set_alarm(2, 5);
        bus.mode = 2'b00;
        wait_ring("ring_both", 800);
        pulse(1'b1, 1'b1);
        check("both_fall", int'(bus.ringing), 0);
        cyc(620);
        check("both_idle", int'(bus.ringing), 0);
        // timeout after 120 ticks
        set_alarm(2, 5);
        bus.mode = 2'b00;
        wait_ring("ring_to", 800);
        count_ticks(1'b0, 1300, n);
        check("timeout_ticks", n, 120);
        check("timeout_fall", int'(bus.ringing), 0);
        // aborts: enable cleared, then set-time mode
        set_alarm(2, 9);
        bus.mode = 2'b00;
        wait_ring("ring_en", 800);
        bus.alarm_en = 4'b0000;
        cyc(1);
        check("abort_en", int'(bus.ringing), 0);
        bus.alarm_en = 4'b0100;
        set_alarm(2, 1);
        bus.mode = 2'b00;
        wait_ring("ring_mode", 800);
        bus.mode = 2'b01;
        cyc(1);
        check("abort_mode", int'(bus.ringing), 0);
        // async reset mid-ring
        set_alarm(2, 1);
        bus.mode = 2'b00;
        wait_ring("ring_rst", 800);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("arst_ringing", int'(bus.ringing), 0);
        check("arst_hrs", int'(bus.hrs), 0);
        check("arst_mins", int'(bus.mins), 0);
        check("arst_secs", int'(bus.secs), 0);
        check("arst_ring_id", int'(bus.ring_id), 0);
        @(negedge clk);
        reset = 1'b0;
        bus.alarm_en = 4'b1111;
        cyc(30);
        check("arst_no_ring", int'(bus.ringing), 0);
        check("arst_alarm_mins", int'(bus.alarm_mins), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alarm_clock_multi.md
# alarm_clock_multi

Parametrised 24-hour clock with N independently enabled alarms, button-driven setting with hold-to-repeat, and a ring/snooze/timeout state machine. It is the successor of the single-alarm clock block and sits between the board buttons/switches and the seven-segment display drivers, which consume its time and selected-alarm outputs.

## Interface
- CLK_HZ, 125000000: clk cycles per second tick.
- REPEAT_DIV, 62500000: cycles between auto-repeat increments while a set button is held.
- NUM_ALARMS, 4: number of alarm registers (≥1).
- SNOOZE_MINS, 5: snooze length in minutes.
- RING_MINS, 10: ring timeout in minutes.

- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high; clears all state.
- mode  in  2  00 run, 01 set time, 10 set alarm, 11 treated as 00.
- alarm_sel  in  AW=max(1,$clog2(NUM_ALARMS))  alarm edited/displayed.
- btn_hr, btn_min  in  1 each  set buttons, level, pre-debounced and synchronous.
- alarm_en  in  NUM_ALARMS  per-alarm enable.
- snooze, stop  in  1 each  levels; rising edge acts.
- hrs  out  5;  mins, secs  out  6 each  current time.
- alarm_hrs  out  5;  alarm_mins  out  6  alarm[alarm_sel].
- ringing  out  1  alarm sounding.
- ring_id  out  AW  index of the active alarm.
- sec_pulse  out  1  one-cycle pulse per second.

## Operation
- Prescaler counts 0..CLK_HZ-1; the wrap cycle is the tick. Ticks advance time only in run mode; in set-time mode the prescaler and secs are held at 0.
- On each tick: secs 59→0 carries to mins; mins 59→0 carries to hrs; hrs 23→0.
- Setting: a button rising edge increments once immediately, then again every REPEAT_DIV cycles while held. Release clears the repeat counter. btn_hr has priority; btn_min is ignored while btn_hr is high.
- Set increments: hrs +1 with 23→0; mins +1 with 59→0 and no carry into hours. In set-time mode they adjust time; in set-alarm mode they adjust alarm[alarm_sel]. In run mode the buttons are ignored.
- Match event: in run mode, a tick moves the time to hh:mm:00 equal to an enabled alarm. Reset and set-mode edits never produce a match. When several alarms match, the lowest index wins.
- FSM states are IDLE, RING and SNOOZE.
  - IDLE→RING on a match: load ring_id and clear the ring timer.
  - RING: ringing=1. A stop edge goes to IDLE. A snooze edge goes to SNOOZE and loads the snooze counter with SNOOZE_MINS*60. After RING_MINS*60 ticks the FSM times out to IDLE. A new match is ignored.
  - SNOOZE: ringing=0 and the counter decrements per tick. At 0 it returns to RING with the timer cleared and ring_id unchanged. A stop edge goes to IDLE. A new match goes to RING with the new ring_id.
  - From RING or SNOOZE, alarm_en[ring_id]=0 or mode≠run forces IDLE.
  - Stop and snooze edges in the same cycle: stop wins.
- Reset values:
  - time 00:00:00;
  - all alarms 00:00;
  - FSM IDLE;
  - ringing=0, ring_id=0, sec_pulse=0;
  - prescaler, repeat, ring and snooze counters 0.

## Timing
- All outputs are registered.
- sec_pulse is high in the cycle after the tick, the same cycle in which the new time is visible.
- ringing rises one cycle after hrs/mins/secs show the matching hh:mm:00, and falls one cycle after the stop or snooze edge is sampled.
- A set increment is visible one cycle after the button rising edge is sampled. Repeats follow at REPEAT_DIV-cycle intervals, so holding a button for K cycles gives 1+floor((K-1)/REPEAT_DIV) increments.
- SNOOZE lasts exactly SNOOZE_MINS*60 ticks. Timeout occurs on the RING_MINS*60-th tick after entering RING.
- reset clears all state immediately and asynchronously, including mid-ring or mid-repeat.
- alarm_hrs/alarm_mins follow alarm_sel with one cycle latency.

## Test plan
All scenarios use CLK_HZ=10, REPEAT_DIV=4, NUM_ALARMS=4, SNOOZE_MINS=1, RING_MINS=2.
- Rollover: set time 23:59, switch to run, apply 60 ticks → 00:00:00 with a sec_pulse every 10 cycles.
- Repeat: in set-time mode hold btn_min for 13 cycles from 00:57 → 4 increments, ending at 00:01 with hrs unchanged at 0. btn_hr and btn_min together → only hrs changes.
- Priority: alarms 1 and 2 at 00:01, both enabled; run from 00:00:00 → ringing rises at 00:01:00+1 cycle with ring_id=1. Alarm 1 disabled → ring_id=2.
- Snooze: while ringing, pulse snooze → ringing=0 for 60 ticks, then 1 again with the same ring_id; pulse stop → IDLE. Stop and snooze in the same cycle → IDLE.
- Timeout and abort: ringing with no input → ringing falls after 120 ticks. Clearing alarm_en[ring_id] or setting mode=01 → immediate IDLE.
- Async reset mid-ring: assert reset between clock edges → ringing=0 and time 00:00:00 before the next edge. No ring occurs at reset even with alarm 0 at 00:00 enabled.
